// File: rtl/file_register.sv
// -----------------------------------------------------------------------------
// file_register
//
// Command decoder and register file sitting between the soft microcontroller's
// GPIO port and the image-convolution datapath. The micro writes 32-bit
// instruction words {enable, command, data}; a command executes once on the
// rising edge of the enable bit. All outputs are registered, so every effect
// becomes visible one clock after the executing edge.
//
// Ports:
//   clock               system clock, rising edge
//   reset               asynchronous, active-high reset
//   i_cmd_from_micro    instruction word {enable, command, data}
//   i_frame_ready       processed frame available in memory (level)
//   i_pixels_from_mem   pixel word returned by frame memory
//   o_data_to_micro     readback register (status / fetched pixels)
//   o_pixels_from_micro pixel word to be written to frame memory
//   o_kernel_sel        selected convolution kernel
//   o_load              one-cycle write strobe for o_pixels_from_micro
//   o_get_pixels        one-cycle read request to frame memory
//   o_start_conv        one-cycle start pulse for the convolver
// -----------------------------------------------------------------------------
module file_register #(
    parameter int NB_C0M  = 7,
    parameter int NB_DATA = 24,
    parameter int NB_INST = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_INST-1:0] i_cmd_from_micro,
    input  logic               i_frame_ready,
    input  logic [NB_INST-1:0] i_pixels_from_mem,
    output logic [NB_INST-1:0] o_data_to_micro,
    output logic [NB_DATA-1:0] o_pixels_from_micro,
    output logic [1:0]         o_kernel_sel,
    output logic               o_load,
    output logic               o_get_pixels,
    output logic               o_start_conv
);

    localparam logic [NB_C0M-1:0] CMD_KERNEL_SEL     = NB_C0M'(0);
    localparam logic [NB_C0M-1:0] CMD_LOAD_FRAME     = NB_C0M'(1);
    localparam logic [NB_C0M-1:0] CMD_END_FRAME      = NB_C0M'(2);
    localparam logic [NB_C0M-1:0] CMD_IS_FRAME_READY = NB_C0M'(3);
    localparam logic [NB_C0M-1:0] CMD_GET_FRAME      = NB_C0M'(4);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t state;
    state_t next_state;

    logic               en_prev;
    logic               enable;
    logic [NB_C0M-1:0]  command;
    logic [NB_DATA-1:0] data;
    logic               execute;

    logic [NB_INST-1:0] next_data_to_micro;
    logic [NB_DATA-1:0] next_pixels;
    logic [1:0]         next_kernel_sel;
    logic               next_load;
    logic               next_get_pixels;
    logic               next_start_conv;

    assign enable  = i_cmd_from_micro[NB_INST-1];
    assign command = i_cmd_from_micro[NB_INST-2:NB_DATA];
    assign data    = i_cmd_from_micro[NB_DATA-1:0];

    // Rising edge of the enable bit; holding enable high runs a command once.
    assign execute = enable & ~en_prev;

    always_comb begin
        next_state         = state;
        next_data_to_micro = o_data_to_micro;
        next_pixels        = o_pixels_from_micro;
        next_kernel_sel    = o_kernel_sel;
        next_load          = 1'b0;
        next_get_pixels    = 1'b0;
        next_start_conv    = 1'b0;

        case (state)
            IDLE: begin
                if (execute) begin
                    case (command)
                        CMD_KERNEL_SEL: begin
                            next_kernel_sel = data[1:0];
                        end
                        CMD_LOAD_FRAME: begin
                            next_pixels = data;
                            next_load   = 1'b1;
                        end
                        CMD_END_FRAME: begin
                            // Last pixel word of the frame also kicks off the convolver.
                            next_pixels     = data;
                            next_load       = 1'b1;
                            next_start_conv = 1'b1;
                        end
                        CMD_IS_FRAME_READY: begin
                            next_data_to_micro = {{(NB_INST-1){1'b0}}, i_frame_ready};
                        end
                        CMD_GET_FRAME: begin
                            next_get_pixels = 1'b1;
                            next_state      = WAIT_MEM;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                // Memory answers one cycle after the request; enable edges
                // seen here are dropped, only en_prev keeps tracking.
                next_data_to_micro = i_pixels_from_mem;
                next_state         = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            en_prev             <= 1'b0;
            o_data_to_micro     <= '0;
            o_pixels_from_micro <= '0;
            o_kernel_sel        <= 2'b00;
            o_load              <= 1'b0;
            o_get_pixels        <= 1'b0;
            o_start_conv        <= 1'b0;
        end else begin
            state               <= next_state;
            en_prev             <= enable;
            o_data_to_micro     <= next_data_to_micro;
            o_pixels_from_micro <= next_pixels;
            o_kernel_sel        <= next_kernel_sel;
            o_load              <= next_load;
            o_get_pixels        <= next_get_pixels;
            o_start_conv        <= next_start_conv;
        end
    end

endmodule

// File: tb/tb_file_register.sv
// -----------------------------------------------------------------------------
// tb_file_register
//
// Directed bench for file_register. Each stimulus step pushes the expected
// output snapshot into a scoreboard queue; the snapshot is popped and compared
// against the DUT outputs on the falling clock edge when they are produced.
// A small frame-memory model answers o_get_pixels requests with a fixed list
// of pixel words.
// -----------------------------------------------------------------------------
module tb_file_register;

    localparam int NB_C0M  = 7;
    localparam int NB_DATA = 24;
    localparam int NB_INST = 32;

    localparam logic [NB_C0M-1:0] KERNEL_SEL     = 7'd0;
    localparam logic [NB_C0M-1:0] LOAD_FRAME     = 7'd1;
    localparam logic [NB_C0M-1:0] END_FRAME      = 7'd2;
    localparam logic [NB_C0M-1:0] IS_FRAME_READY = 7'd3;
    localparam logic [NB_C0M-1:0] GET_FRAME      = 7'd4;

    logic               clock;
    logic               reset;
    logic [NB_INST-1:0] i_cmd_from_micro;
    logic               i_frame_ready;
    logic [NB_INST-1:0] i_pixels_from_mem;
    logic [NB_INST-1:0] o_data_to_micro;
    logic [NB_DATA-1:0] o_pixels_from_micro;
    logic [1:0]         o_kernel_sel;
    logic               o_load;
    logic               o_get_pixels;
    logic               o_start_conv;

    file_register #(
        .NB_C0M (NB_C0M),
        .NB_DATA(NB_DATA),
        .NB_INST(NB_INST)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .i_cmd_from_micro   (i_cmd_from_micro),
        .i_frame_ready      (i_frame_ready),
        .i_pixels_from_mem  (i_pixels_from_mem),
        .o_data_to_micro    (o_data_to_micro),
        .o_pixels_from_micro(o_pixels_from_micro),
        .o_kernel_sel       (o_kernel_sel),
        .o_load             (o_load),
        .o_get_pixels       (o_get_pixels),
        .o_start_conv       (o_start_conv)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Frame-memory model: a request seen in a cycle is answered within that
    // same cycle, ready for the DUT's next rising edge.
    logic [NB_DATA-1:0] mem_words [4];
    int                 mem_idx;

    initial begin
        mem_words[0] = 24'h2BFF1D;
        mem_words[1] = 24'h7FABFF;
        mem_words[2] = 24'h00FF00;
        mem_words[3] = 24'h123456;
        mem_idx = 0;
        i_pixels_from_mem = '0;
    end

    always @(negedge clock) begin
        if (o_get_pixels === 1'b1) begin
            i_pixels_from_mem = {8'h00, mem_words[mem_idx % 4]};
            mem_idx = mem_idx + 1;
        end
    end

    typedef struct {
        logic [1:0]         kernel;
        logic [NB_DATA-1:0] pixels;
        logic [NB_INST-1:0] data;
        logic               load;
        logic               start;
        logic               get;
    } snap_t;

    snap_t sb[$];

    logic [1:0]         exp_kernel;
    logic [NB_DATA-1:0] exp_pixels;
    logic [NB_INST-1:0] exp_data;
    int                 exp_rd;

    int n_checks;
    int n_fail;

    task automatic cmp(input string tag, input logic [NB_INST-1:0] obs, input logic [NB_INST-1:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic push(input logic load, input logic start, input logic get);
        snap_t s;
        s.kernel = exp_kernel;
        s.pixels = exp_pixels;
        s.data   = exp_data;
        s.load   = load;
        s.start  = start;
        s.get    = get;
        sb.push_back(s);
    endtask

    task automatic check_now(input string tag);
        snap_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected a snapshot", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({tag, ".kernel"}, 32'(o_kernel_sel),        32'(e.kernel));
            cmp({tag, ".pixels"}, 32'(o_pixels_from_micro), 32'(e.pixels));
            cmp({tag, ".data"},   o_data_to_micro,          e.data);
            cmp({tag, ".load"},   32'(o_load),              32'(e.load));
            cmp({tag, ".start"},  32'(o_start_conv),        32'(e.start));
            cmp({tag, ".get"},    32'(o_get_pixels),        32'(e.get));
        end
    endtask

    task automatic tick_check(input string tag);
        @(posedge clock);
        @(negedge clock);
        check_now(tag);
    endtask

    // One full enable 0->1->0 strobe; caller is positioned on a falling edge.
    task automatic strobe(input string tag, input logic [NB_C0M-1:0] cmd, input logic [NB_DATA-1:0] d);
        logic l, s, g;
        l = 1'b0; s = 1'b0; g = 1'b0;
        i_cmd_from_micro = {1'b1, cmd, d};
        case (cmd)
            KERNEL_SEL:     exp_kernel = d[1:0];
            LOAD_FRAME:     begin exp_pixels = d; l = 1'b1; end
            END_FRAME:      begin exp_pixels = d; l = 1'b1; s = 1'b1; end
            IS_FRAME_READY: exp_data = {31'b0, i_frame_ready};
            GET_FRAME:      g = 1'b1;
            default:        ;
        endcase
        push(l, s, g);
        tick_check({tag, "_c1"});
        i_cmd_from_micro = {1'b0, cmd, d};
        if (cmd == GET_FRAME) begin
            exp_data = {8'h00, mem_words[exp_rd % 4]};
            exp_rd++;
        end
        push(1'b0, 1'b0, 1'b0);
        tick_check({tag, "_c2"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_kernel = 2'b00;
        exp_pixels = '0;
        exp_data   = '0;
        exp_rd     = 0;

        reset            = 1'b1;
        i_cmd_from_micro = '0;
        i_frame_ready    = 1'b0;
        repeat (2) @(negedge clock);
        push(1'b0, 1'b0, 1'b0);
        check_now("reset");
        reset = 1'b0;
        push(1'b0, 1'b0, 1'b0);
        tick_check("idle");

        // Kernel select, including upper data bits that must be ignored.
        strobe("ksel3", KERNEL_SEL, 24'h000003);
        strobe("ksel2", KERNEL_SEL, 24'h000002);
        strobe("ksel_hi", KERNEL_SEL, 24'hFFFFFD);

        // Frame-ready status readback.
        i_frame_ready = 1'b1;
        strobe("rdy1", IS_FRAME_READY, 24'h000000);
        i_frame_ready = 1'b0;
        strobe("rdy0", IS_FRAME_READY, 24'h000000);

        // Pixel loads and end of frame.
        strobe("load_a", LOAD_FRAME, 24'h2BFF1D);
        strobe("load_b", LOAD_FRAME, 24'h7FABFF);
        strobe("endfr", END_FRAME, 24'h00FF00);

        // Unknown command code leaves every output untouched.
        strobe("unk", 7'd9, 24'hABCDEF);

        // Three fetches from the memory model.
        strobe("get0", GET_FRAME, 24'h000000);
        strobe("get1", GET_FRAME, 24'h000000);
        strobe("get2", GET_FRAME, 24'h000000);

        // Enable held high for 5 cycles: exactly one load pulse.
        i_cmd_from_micro = {1'b1, LOAD_FRAME, 24'h55AA55};
        exp_pixels = 24'h55AA55;
        push(1'b1, 1'b0, 1'b0);
        tick_check("held_c1");
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b0, 1'b0);
            tick_check("held_hi");
        end
        i_cmd_from_micro = {1'b0, LOAD_FRAME, 24'h55AA55};
        push(1'b0, 1'b0, 1'b0);
        tick_check("held_lo");

        // Reset while the fetch is pending in WAIT_MEM.
        i_cmd_from_micro = {1'b1, GET_FRAME, 24'h000000};
        push(1'b0, 1'b0, 1'b1);
        tick_check("getrst_req");
        reset            = 1'b1;
        i_cmd_from_micro = '0;
        #1;
        exp_kernel = 2'b00;
        exp_pixels = '0;
        exp_data   = '0;
        push(1'b0, 1'b0, 1'b0);
        check_now("rst_waitmem");
        @(negedge clock);
        reset = 1'b0;
        push(1'b0, 1'b0, 1'b0);
        tick_check("post_rst1");
        push(1'b0, 1'b0, 1'b0);
        tick_check("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
